// File: rtl/proc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package  : proc_pkg                                                         |
// | Purpose  : Shared opcodes, instruction field positions, stall-cause codes.  |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package proc_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 17;
  localparam int RT_HI  = 16;
  localparam int RT_LO  = 12;

  localparam logic [1:0] STALL_NONE     = 2'b00;
  localparam logic [1:0] STALL_LOAD_USE = 2'b01;
  localparam logic [1:0] STALL_PENDING  = 2'b10;
  localparam logic [1:0] STALL_MULTDIV  = 2'b11;

  localparam logic [4:0] REG_STATUS = 5'd30;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage : proc_pkg
`default_nettype wire

// File: rtl/fd_src_decode.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : fd_src_decode                                                    |
// | Purpose  : Extracts the (up to two) source registers read by the F/D instr. |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module fd_src_decode
  import proc_pkg::*;
(
  input  logic [31:0] ir_fd,
  output logic [4:0]  src0,
  output logic [4:0]  src1,
  output logic        src0_v,
  output logic        src1_v,
  output logic        is_blt
);

  logic [4:0] w_op;
  logic [4:0] w_rd;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_src0;
  logic [4:0] w_src1;
  logic       w_v0;
  logic       w_v1;
  logic       w_unused_imm;

  assign w_op = ir_fd[OPC_HI:OPC_LO];
  assign w_rd = ir_fd[RD_HI:RD_LO];
  assign w_rs = ir_fd[RS_HI:RS_LO];
  assign w_rt = ir_fd[RT_HI:RT_LO];
  assign w_unused_imm = ^ir_fd[RT_LO-1:0];

  always_comb begin
    w_src0 = '0;
    w_src1 = '0;
    w_v0   = 1'b0;
    w_v1   = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_src0 = w_rs;  w_v0 = 1'b1;
        w_src1 = w_rt;  w_v1 = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        w_src0 = w_rs;  w_v0 = 1'b1;
      end
      // Stores and branches read the rd field as a data source.
      OP_SW, OP_BNE, OP_BLT: begin
        w_src0 = w_rd;  w_v0 = 1'b1;
        w_src1 = w_rs;  w_v1 = 1'b1;
      end
      OP_JR: begin
        w_src0 = w_rd;  w_v0 = 1'b1;
      end
      OP_BEX: begin
        w_src0 = REG_STATUS;  w_v0 = 1'b1;
      end
      default: ;
    endcase
  end

  assign src0   = w_src0;
  assign src1   = w_src1;
  assign src0_v = w_v0 & (w_src0 != 5'd0);
  assign src1_v = w_v1 & (w_src1 != 5'd0);
  assign is_blt = (w_op == OP_BLT);

endmodule : fd_src_decode
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : hazard_scoreboard                                                |
// | Purpose  : Load-use / load-latency scoreboard and multdiv busy stall unit.  |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module hazard_scoreboard
  import proc_pkg::*;
#(
  parameter  int NUM_REGS   = 32,
  parameter  int LOAD_LAT   = 0,
  parameter  int BLT_EXEMPT = 1,
  parameter  int CNT_W      = 16,
  localparam int RW         = $clog2(NUM_REGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      ir_fd,
  input  logic [31:0]      ir_dx,
  input  logic [RW-1:0]    dest_dx,
  input  logic             dx_valid,
  input  logic             flush,
  input  logic             md_start,
  input  logic             md_ready,
  output logic             stall,
  output logic [1:0]       stall_cause,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int             CW       = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0]  C_RELOAD = CW'(LOAD_LAT);

  logic [4:0]          w_src0;
  logic [4:0]          w_src1;
  logic                w_src0_v;
  logic                w_src1_v;
  logic                w_is_blt;
  logic [RW-1:0]       w_src0_idx;
  logic [RW-1:0]       w_src1_idx;
  logic                w_exempt;
  logic                w_load_dx;
  logic                w_lu_hit;
  logic                w_load_use;
  logic                w_pend_hit;
  logic                w_pending;
  logic [NUM_REGS-1:0] w_cnt_nz;
  logic                w_unused_dx;

  md_state_t           r_md_state;
  md_state_t           w_md_next;
  logic [CNT_W-1:0]    r_stall_cycles;

  fd_src_decode u_fd_dec (
    .ir_fd  (ir_fd),
    .src0   (w_src0),
    .src1   (w_src1),
    .src0_v (w_src0_v),
    .src1_v (w_src1_v),
    .is_blt (w_is_blt)
  );

  assign w_src0_idx  = w_src0[RW-1:0];
  assign w_src1_idx  = w_src1[RW-1:0];
  assign w_exempt    = (BLT_EXEMPT != 0) && w_is_blt;
  assign w_unused_dx = ^ir_dx[OPC_LO-1:0];

  assign w_load_dx  = (ir_dx[OPC_HI:OPC_LO] == OP_LW) && dx_valid && (dest_dx != '0);
  assign w_lu_hit   = w_load_dx &&
                      ((w_src0_v && (w_src0_idx == dest_dx)) ||
                       (w_src1_v && (w_src1_idx == dest_dx)));
  assign w_load_use = w_lu_hit && !w_exempt;

  // One down-counter per register; a load entering X reloads it, otherwise it drains.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_cnt <= '0;
      end else if (w_load_dx && (dest_dx == RW'(gi))) begin
        r_cnt <= C_RELOAD;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end

    assign w_cnt_nz[gi] = (r_cnt != '0);
  end

  assign w_pend_hit = (w_src0_v && w_cnt_nz[w_src0_idx]) ||
                      (w_src1_v && w_cnt_nz[w_src1_idx]);
  assign w_pending  = w_pend_hit && !w_exempt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_md_state <= MD_IDLE;
    end else begin
      r_md_state <= w_md_next;
    end
  end

  // A new start alongside the ready pulse keeps the unit busy for the next op.
  always_comb begin
    w_md_next = r_md_state;
    case (r_md_state)
      MD_IDLE: if (md_start)              w_md_next = MD_BUSY;
      MD_BUSY: if (md_ready && !md_start) w_md_next = MD_IDLE;
      default:                            w_md_next = MD_IDLE;
    endcase
  end

  assign md_busy = (r_md_state == MD_BUSY);

  always_comb begin
    stall       = 1'b0;
    stall_cause = STALL_NONE;
    if (!flush) begin
      if (md_busy) begin
        stall       = 1'b1;
        stall_cause = STALL_MULTDIV;
      end else if (w_load_use) begin
        stall       = 1'b1;
        stall_cause = STALL_LOAD_USE;
      end else if (w_pending) begin
        stall       = 1'b1;
        stall_cause = STALL_PENDING;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
    end else if (stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule : hazard_scoreboard
`default_nettype wire
